// File: rtl/hpdcache_pkg.sv
// Shared types and helpers for the HPDcache victim selection path.
// Latency: none (package only).
// Backpressure: not applicable.
package hpdcache_pkg;

  // Replacement policy chosen at elaboration time.
  typedef enum logic {
    PLRU = 1'b0,
    RR   = 1'b1
  } hpdcache_victim_policy_e;

  // Helpers scan a 32-bit window, so way counts are limited to 32.
  localparam int unsigned HPDCACHE_MAX_WAYS = 32;

  // Index of the first set bit at or after 'start', wrapping at n-1 -> 0.
  // Returns n when no bit in [0, n) is set.
  function automatic int unsigned hpdcache_first_one_from(
    input logic [31:0] v,
    input int unsigned start,
    input int unsigned n
  );
    int unsigned res;
    int unsigned idx;
    logic        found;
    res   = n;
    found = 1'b0;
    for (int unsigned i = 0; i < HPDCACHE_MAX_WAYS; i++) begin
      idx = start + i;
      if (idx >= n) idx = idx - n;
      if ((i < n) && !found && v[idx[4:0]]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Index of the lowest set bit; n when none.
  function automatic int unsigned hpdcache_first_one(
    input logic [31:0] v,
    input int unsigned n
  );
    return hpdcache_first_one_from(v, 0, n);
  endfunction

endpackage

// File: rtl/hpdcache_prio_rr_arb.sv
// Rotating-priority first-one picker: grants the first request at or after 'start'.
// Latency: combinational.
// Backpressure: none; the grant simply follows the request vector.
module hpdcache_prio_rr_arb
  import hpdcache_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         gnt_vld,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);

  int unsigned idx;

  // Scan upward from the start index, wrapping at N-1.
  always_comb begin
    idx     = hpdcache_first_one_from(32'(req), 32'(start), N);
    gnt_vld = |req;
    gnt_idx = gnt_vld ? W'(idx) : '0;
    gnt     = gnt_vld ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/hpdcache_victim_sel_pipe.sv
// Set-associative victim selector (PLRU or per-set round-robin); optional lock mask via HPDCACHE_VICTIM_SEL_LOCK_EN.
// Latency: result registered exactly one cycle after sel_victim_i.
// Backpressure: none; a new request may be issued every cycle.
module hpdcache_victim_sel_pipe
  import hpdcache_pkg::*;
#(
  parameter int unsigned Sets        = 64,
  parameter int unsigned Ways        = 4,
  parameter int unsigned Policy      = 0,
  parameter bit          PreferClean = 1'b1,
  parameter int unsigned SetW        = (Sets > 1) ? $clog2(Sets) : 1,
  parameter int unsigned WayW        = (Ways > 1) ? $clog2(Ways) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            updt_i,
  input  logic [SetW-1:0] updt_set_i,
  input  logic [Ways-1:0] updt_way_i,
  input  logic            sel_victim_i,
  input  logic [SetW-1:0] sel_victim_set_i,
  input  logic [Ways-1:0] sel_dir_valid_i,
  input  logic [Ways-1:0] sel_dir_dirty_i,
  input  logic [Ways-1:0] sel_dir_fetch_i,
`ifdef HPDCACHE_VICTIM_SEL_LOCK_EN
  input  logic [Ways-1:0] sel_lock_i,
`endif
  output logic            sel_valid_o,
  output logic [Ways-1:0] sel_victim_way_o,
  output logic            sel_none_o
);

  localparam hpdcache_victim_policy_e Pol = (Policy == 1) ? RR : PLRU;

  logic [Ways-1:0] elig, inv, clean, cand;
  logic [WayW-1:0] inv_idx;
  logic [Ways-1:0] victim;
  logic [WayW-1:0] victim_idx;
  logic            none;
  logic            sel_hit;

  logic [Ways-1:0] arb_req;
  logic [WayW-1:0] arb_start;
  logic            arb_vld;
  logic [Ways-1:0] arb_gnt;
  logic [WayW-1:0] arb_idx;

  // Candidate masks: ways being refilled (and locked ways) can never be chosen.
  always_comb begin
`ifdef HPDCACHE_VICTIM_SEL_LOCK_EN
    elig = ~sel_dir_fetch_i & ~sel_lock_i;
`else
    elig = ~sel_dir_fetch_i;
`endif
    inv     = elig & ~sel_dir_valid_i;
    clean   = elig & ~sel_dir_dirty_i;
    cand    = (PreferClean && (|clean)) ? clean : elig;
    inv_idx = WayW'(hpdcache_first_one(32'(inv), Ways));
  end

  hpdcache_prio_rr_arb #(
    .N (Ways),
    .W (WayW)
  ) u_arb (
    .req     (arb_req),
    .start   (arb_start),
    .gnt_vld (arb_vld),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Empty ways win outright; otherwise the policy arbiter picks among candidates.
  always_comb begin
    victim     = '0;
    victim_idx = '0;
    none       = 1'b0;
    if (|inv) begin
      victim     = Ways'(1) << inv_idx;
      victim_idx = inv_idx;
    end else if (arb_vld) begin
      victim     = arb_gnt;
      victim_idx = arb_idx;
    end else begin
      none = 1'b1;
    end
    sel_hit = sel_victim_i & (|victim);
  end

  if (Pol == PLRU) begin : g_plru
    logic [Ways-1:0] mru_q [Sets];
    logic [Ways-1:0] row_sel, old_cand;
    logic [Ways-1:0] acc_sel, acc_upd, or_sel, or_upd, nxt_sel, nxt_upd;
    logic            updt_act, same_set;

    // Prefer candidates whose MRU bit is clear; fall back to any candidate.
    always_comb begin
      row_sel   = mru_q[sel_victim_set_i];
      old_cand  = cand & ~row_sel;
      arb_req   = (|old_cand) ? old_cand : cand;
      arb_start = '0;
    end

    // Merge hit and selection accesses into one write per row; a row that
    // would become all-ones collapses to just the ways accessed now.
    always_comb begin
      updt_act = updt_i & (|updt_way_i);
      same_set = updt_act & sel_hit & (updt_set_i == sel_victim_set_i);
      acc_sel  = victim | (same_set ? updt_way_i : '0);
      acc_upd  = updt_way_i | (same_set ? victim : '0);
      or_sel   = row_sel | acc_sel;
      or_upd   = mru_q[updt_set_i] | acc_upd;
      nxt_sel  = (&or_sel) ? acc_sel : or_sel;
      nxt_upd  = (&or_upd) ? acc_upd : or_upd;
    end

    // MRU rows: cleared on reset, written by hits and by selections.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        for (int s = 0; s < Sets; s++) mru_q[s] <= '0;
      end else begin
        if (updt_act) mru_q[updt_set_i] <= nxt_upd;
        if (sel_hit)  mru_q[sel_victim_set_i] <= nxt_sel;
      end
    end
  end else begin : g_rr
    logic [WayW-1:0] ptr_q [Sets];
    logic [WayW-1:0] ptr_nxt;
    logic            unused_updt;

    // Hits do not influence round-robin order.
    assign unused_updt = ^{updt_i, updt_set_i, updt_way_i};

    // Scan from the set's pointer; the next pointer follows the victim.
    always_comb begin
      arb_req   = cand;
      arb_start = ptr_q[sel_victim_set_i];
      ptr_nxt   = (victim_idx == WayW'(Ways - 1)) ? '0 : victim_idx + WayW'(1);
    end

    // Per-set pointers: cleared on reset, advanced on each successful selection.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        for (int s = 0; s < Sets; s++) ptr_q[s] <= '0;
      end else if (sel_hit) begin
        ptr_q[sel_victim_set_i] <= ptr_nxt;
      end
    end
  end

  // Register the selection result; requests during reset are dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sel_valid_o      <= 1'b0;
      sel_victim_way_o <= '0;
      sel_none_o       <= 1'b0;
    end else begin
      sel_valid_o      <= sel_victim_i;
      sel_victim_way_o <= sel_victim_i ? victim : '0;
      sel_none_o       <= sel_victim_i & none;
    end
  end

endmodule

// File: tb/tb_hpdcache_victim_sel_pipe.sv
// Bench for hpdcache_victim_sel_pipe: a PLRU and a round-robin instance share stimulus.
// Latency: results are checked one cycle after each request.
// Backpressure: none exercised; requests may be issued every cycle.
module tb_hpdcache_victim_sel_pipe;

  localparam logic [4:0] USE_MODEL = 5'b11111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       updt;
  logic [2:0] updt_set;
  logic [3:0] updt_way;
  logic       sel;
  logic [2:0] sel_set;
  logic [3:0] dir_valid, dir_dirty, dir_fetch, lock;
  logic       p_vld, p_none, r_vld, r_none;
  logic [3:0] p_way, r_way;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [5:0] qp[$];
  logic [5:0] qr[$];

  logic [3:0] m_mru [8];
  logic [1:0] m_ptr [8];

  always #5 clk = ~clk;

  hpdcache_victim_sel_pipe #(
    .Sets(8), .Ways(4), .Policy(0), .PreferClean(1'b1)
  ) u_plru (
    .clk_i(clk), .rst_ni(rst_n),
    .updt_i(updt), .updt_set_i(updt_set), .updt_way_i(updt_way),
    .sel_victim_i(sel), .sel_victim_set_i(sel_set),
    .sel_dir_valid_i(dir_valid), .sel_dir_dirty_i(dir_dirty), .sel_dir_fetch_i(dir_fetch),
`ifdef HPDCACHE_VICTIM_SEL_LOCK_EN
    .sel_lock_i(lock),
`endif
    .sel_valid_o(p_vld), .sel_victim_way_o(p_way), .sel_none_o(p_none)
  );

  hpdcache_victim_sel_pipe #(
    .Sets(8), .Ways(4), .Policy(1), .PreferClean(1'b1)
  ) u_rr (
    .clk_i(clk), .rst_ni(rst_n),
    .updt_i(updt), .updt_set_i(updt_set), .updt_way_i(updt_way),
    .sel_victim_i(sel), .sel_victim_set_i(sel_set),
    .sel_dir_valid_i(dir_valid), .sel_dir_dirty_i(dir_dirty), .sel_dir_fetch_i(dir_fetch),
`ifdef HPDCACHE_VICTIM_SEL_LOCK_EN
    .sel_lock_i(lock),
`endif
    .sel_valid_o(r_vld), .sel_victim_way_o(r_way), .sel_none_o(r_none)
  );

  // Reference selection: returns {none, way}.
  function automatic logic [4:0] model_sel(input bit rr, input logic [2:0] s,
                                           input logic [3:0] v, input logic [3:0] d,
                                           input logic [3:0] f, input logic [3:0] k);
    logic [3:0] el, iv, cl, cd, pick;
    int p;
    el = ~f & ~k;
    iv = el & ~v;
    cl = el & ~d;
    cd = (cl != 4'b0) ? cl : el;
    pick = 4'b0;
    if (iv != 4'b0) begin
      for (int i = 3; i >= 0; i--) if (iv[i]) pick = 4'b0001 << i;
      return {1'b0, pick};
    end
    if (cd == 4'b0) return 5'b10000;
    if (!rr) begin
      for (int i = 3; i >= 0; i--) if (cd[i] && !m_mru[s][i]) pick = 4'b0001 << i;
      if (pick == 4'b0)
        for (int i = 3; i >= 0; i--) if (cd[i]) pick = 4'b0001 << i;
    end else begin
      for (int j = 3; j >= 0; j--) begin
        p = (int'(m_ptr[s]) + j) % 4;
        if (cd[p]) pick = 4'b0001 << p;
      end
    end
    return {1'b0, pick};
  endfunction

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed {vld,none,way}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, push expectations, advance, pop and compare.
  task automatic cyc(input bit req, input logic [2:0] s, input logic [3:0] v,
                     input logic [3:0] d, input logic [3:0] f, input logic [3:0] k,
                     input bit up, input logic [2:0] us, input logic [3:0] uw,
                     input logic [4:0] xp, input logic [4:0] xr, input string tag);
    logic [4:0] mp, mr;
    logic [3:0] acc, row;
    sel = req; sel_set = s; dir_valid = v; dir_dirty = d; dir_fetch = f; lock = k;
    updt = up; updt_set = us; updt_way = uw;
    mp = model_sel(1'b0, s, v, d, f, k);
    mr = model_sel(1'b1, s, v, d, f, k);
    qp.push_back(req ? {1'b1, (xp == USE_MODEL) ? mp : xp} : 6'b0);
    qr.push_back(req ? {1'b1, (xr == USE_MODEL) ? mr : xr} : 6'b0);
    // PLRU model update
    acc = req ? mp[3:0] : 4'b0;
    if (up && uw != 4'b0) begin
      if (req && us == s) acc = acc | uw;
      else begin
        row = m_mru[us] | uw;
        m_mru[us] = (row == 4'hF) ? uw : row;
      end
    end
    if (acc != 4'b0) begin
      row = m_mru[s] | acc;
      m_mru[s] = (row == 4'hF) ? acc : row;
    end
    // Round-robin model update
    if (req && mr[3:0] != 4'b0)
      for (int i = 0; i < 4; i++) if (mr[i]) m_ptr[s] = 2'((i + 1) % 4);
    @(posedge clk);
    #1;
    chk({tag, "/plru"}, {p_vld, p_none, p_way}, qp.pop_front());
    chk({tag, "/rr"}, {r_vld, r_none, r_way}, qr.pop_front());
  endtask

  initial begin
    logic [3:0] rv, rd, rf, rk, ruw;
    logic [2:0] rs, rus;
    for (int i = 0; i < 8; i++) begin m_mru[i] = 4'b0; m_ptr[i] = 2'b0; end
    // Reset with a request present: it must be dropped.
    rst_n = 1'b0; updt = 1'b1; updt_set = 3'd1; updt_way = 4'b0001;
    sel = 1'b1; sel_set = 3'd1; dir_valid = 4'hF; dir_dirty = 4'h0; dir_fetch = 4'h0; lock = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/plru", {p_vld, p_none, p_way}, 6'b0);
    chk("reset/rr", {r_vld, r_none, r_way}, 6'b0);
    rst_n = 1'b1;

    // Invalid way preferred, no policy lookup.
    cyc(1, 3'd3, 4'b1011, 4'h0, 4'h0, 4'h0, 0, 3'd0, 4'h0, 5'b00100, 5'b00100, "inv_first");
    // PLRU: fill MRU bits of set 2, then select twice.
    cyc(0, 3'd0, 4'hF, 4'h0, 4'h0, 4'h0, 1, 3'd2, 4'b0001, USE_MODEL, USE_MODEL, "updt0");
    cyc(0, 3'd0, 4'hF, 4'h0, 4'h0, 4'h0, 1, 3'd2, 4'b0010, USE_MODEL, USE_MODEL, "updt1");
    cyc(0, 3'd0, 4'hF, 4'h0, 4'h0, 4'h0, 1, 3'd2, 4'b0100, USE_MODEL, USE_MODEL, "updt2");
    cyc(1, 3'd2, 4'hF, 4'h0, 4'h0, 4'h0, 0, 3'd0, 4'h0, 5'b01000, USE_MODEL, "plru_sat");
    cyc(1, 3'd2, 4'hF, 4'h0, 4'h0, 4'h0, 0, 3'd0, 4'h0, 5'b00001, USE_MODEL, "plru_after_sat");
    // Round-robin walk and wrap on set 5, back to back.
    cyc(1, 3'd5, 4'hF, 4'h0, 4'h0, 4'h0, 0, 3'd0, 4'h0, USE_MODEL, 5'b00001, "rr0");
    cyc(1, 3'd5, 4'hF, 4'h0, 4'h0, 4'h0, 0, 3'd0, 4'h0, USE_MODEL, 5'b00010, "rr1");
    cyc(1, 3'd5, 4'hF, 4'h0, 4'h0, 4'h0, 0, 3'd0, 4'h0, USE_MODEL, 5'b00100, "rr2");
    cyc(1, 3'd5, 4'hF, 4'h0, 4'h0, 4'h0, 0, 3'd0, 4'h0, USE_MODEL, 5'b01000, "rr3");
    cyc(1, 3'd5, 4'hF, 4'h0, 4'h0, 4'h0, 0, 3'd0, 4'h0, USE_MODEL, 5'b00001, "rr_wrap");
    // Clean preference, then everything fetching.
    cyc(1, 3'd4, 4'hF, 4'b0011, 4'h0, 4'h0, 0, 3'd0, 4'h0, 5'b00100, 5'b00100, "clean_pref");
    cyc(1, 3'd4, 4'hF, 4'b0011, 4'hF, 4'h0, 0, 3'd0, 4'h0, 5'b10000, 5'b10000, "all_fetch");
    // Simultaneous hit update and selection on set 0.
    cyc(0, 3'd0, 4'hF, 4'h0, 4'h0, 4'h0, 1, 3'd0, 4'b0100, USE_MODEL, USE_MODEL, "updt_s0_2");
    cyc(0, 3'd0, 4'hF, 4'h0, 4'h0, 4'h0, 1, 3'd0, 4'b1000, USE_MODEL, USE_MODEL, "updt_s0_3");
    cyc(1, 3'd0, 4'hF, 4'h0, 4'h0, 4'h0, 1, 3'd0, 4'b0010, 5'b00001, USE_MODEL, "same_cycle");
    cyc(1, 3'd0, 4'hF, 4'h0, 4'h0, 4'h0, 0, 3'd0, 4'h0, 5'b00100, USE_MODEL, "merged_row");
    // Simultaneous update and selection on different sets.
    cyc(1, 3'd6, 4'hF, 4'h0, 4'h0, 4'h0, 1, 3'd1, 4'b0001, USE_MODEL, USE_MODEL, "diff_sets");
    cyc(1, 3'd1, 4'hF, 4'h0, 4'h0, 4'h0, 0, 3'd0, 4'h0, 5'b00010, USE_MODEL, "diff_sets_chk");
`ifdef HPDCACHE_VICTIM_SEL_LOCK_EN
    cyc(1, 3'd7, 4'b0110, 4'h0, 4'h0, 4'b0111, 0, 3'd0, 4'h0, 5'b01000, 5'b01000, "lock");
`endif
    // Random traffic checked against the reference model.
    for (int n = 0; n < 300; n++) begin
      rs  = 3'($urandom_range(0, 7));
      rus = 3'($urandom_range(0, 7));
      rv  = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      rd  = 4'($urandom_range(0, 15));
      rf  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      rk  = 4'h0;
`ifdef HPDCACHE_VICTIM_SEL_LOCK_EN
      rk  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
`endif
      ruw = 4'b0001 << $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) ruw = 4'h0;
      cyc(1'($urandom_range(0, 3) != 0), rs, rv, rd, rf, rk, 1'($urandom_range(0, 1)), rus, ruw,
          USE_MODEL, USE_MODEL, "rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hpdcache_victim_sel_pipe.md
Name: hpdcache_victim_sel_pipe

Overview:
- Next-generation set-associative victim selector for the HPDcache miss/refill path.
- Generalises way count and set count, and selects the policy at elaboration time: tree-free PLRU (one MRU bit per way) or per-set round-robin.
- Adds fetch-pending exclusion, clean-way preference, a registered one-cycle selection result and an explicit "no victim" indication.
- Sits between the directory read stage and the refill/MSHR allocation logic.

Parameters:
- Sets, 64, number of cache sets; state array depth.
- Ways, 4, number of ways; integer ≥ 2, need not be a power of 2.
- Policy, 0, replacement policy: 0 = PLRU (MRU bit per way), 1 = round-robin pointer per set.
- PreferClean, 1, when 1, clean eligible ways are chosen ahead of dirty ones.
- SetW, $clog2(Sets), set index width (derived).
- WayW, $clog2(Ways), way index width (derived).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- updt_i  in  1  access-hit update strobe.
- updt_set_i  in  SetW  set for the update.
- updt_way_i  in  Ways  one-hot way accessed.
- sel_victim_i  in  1  selection request.
- sel_victim_set_i  in  SetW  set to select in.
- sel_dir_valid_i  in  Ways  directory valid bits.
- sel_dir_dirty_i  in  Ways  directory dirty bits.
- sel_dir_fetch_i  in  Ways  refill-in-flight bits; these ways are never chosen.
- sel_valid_o  out  1  result valid; one cycle after sel_victim_i.
- sel_victim_way_o  out  Ways  one-hot victim way; all zeros when none.
- sel_none_o  out  1  no eligible way; qualified by sel_valid_o.

Behaviour:
- Reset, synchronous when rst_ni=0 at a clk_i edge:
  - all state bits/pointers := 0;
  - sel_valid_o := 0, sel_victim_way_o := 0, sel_none_o := 0;
  - a request in the reset cycle is dropped.
- State storage:
  - PLRU: Sets×Ways bit array.
  - Round-robin: Sets×WayW pointer array, pointer < Ways always.
- Eligibility: elig = ~sel_dir_fetch_i. Empty candidates: inv = elig & ~valid.
- Selection, combinational from inputs and current state, registered to outputs at the next edge:
  1. If inv≠0: victim = lowest-index bit of inv; no policy lookup.
  2. Else, if PreferClean=1 and (elig & ~dirty)≠0: cand = elig & ~dirty; otherwise cand = elig.
  3. If cand=0: sel_none_o=1 and sel_victim_way_o=0.
  4. PLRU: victim = lowest-index way in cand with MRU bit 0; if none, the lowest-index way in cand.
  5. Round-robin: victim = first way in cand scanning upward from ptr[set] and wrapping at Ways-1 → 0.
- Latency: exactly 1 cycle. Back-to-back requests each cycle are allowed; there is no stall or backpressure.
- State update on selection (victim≠0, and also when case 1 applies):
  - PLRU: victim's bit treated as an access.
  - Round-robin: ptr[set] := (victim index + 1) mod Ways.
- State update on updt_i, PLRU only:
  - set bit of updt_way_i;
  - if the result would be all-ones, the row becomes exactly the one-hot of the accessed way(s).
  - Round-robin ignores updt_i.
- Simultaneous updt_i and sel_victim_i:
  - Selection uses pre-update state.
  - Same set, PLRU: both ways are OR-ed as accesses in one write, and the saturation rule is applied once to the merged row.
  - Different sets: both writes occur.
- updt_way_i must be one-hot; zero means no-op. Set indices ≥ Sets are undefined.

Optional Feature:
- HPDCACHE_VICTIM_SEL_LOCK_EN defined:
  - adds input sel_lock_i [Ways] and sets elig = ~sel_dir_fetch_i & ~sel_lock_i;
  - locked ways are also excluded from case 1.
- Undefined: no port; elig as above.

Decomposition:
- hpdcache_pkg holds the policy enum hpdcache_victim_policy_e {PLRU, RR} and the helper function for lowest-one-hot / rotate-priority.
- One sub-module, hpdcache_prio_rr_arb, gives a rotating first-one from a start index; used by round-robin and reusable elsewhere.

Test Plan (Ways=4, Sets=8 unless noted):
- Reset, then sel set 3 with valid=4'b1011, fetch=0 → next cycle sel_valid_o=1, way=4'b0100, none=0.
- PLRU, all valid/clean: updt set 2 with ways 0,1,2 in sequence → bits 0111; sel set 2 → 4'b1000 and row saturates to 1000; a second sel → 4'b0001.
- Round-robin: four sel to set 5, all valid, fetch=0 → ways 0001, 0010, 0100, 1000, then 0001 again (wrap).
- PreferClean=1, PLRU bits 0000, all valid, dirty=4'b0011 → 4'b0100; with fetch=4'b1111 → none=1, way=0000.
- Same-cycle updt way 1 and sel on set 0, PLRU bits 1100, all valid → victim 0001 (pre-update state); next row = 1111 saturated → 0011.
- With LOCK_EN, lock=4'b0111, valid=4'b0110 → case 1 skipped for the locked invalid way 0; victim 1000.
